// File: rtl/regfile_wb_pkg.sv
// Shared types and constants for the register-file write-back arbiter.
//
// Contents:
//   state_t      - top-level sequencing: CLEAR zeroes the file, RUN arbitrates
//   REQ_A/REQ_B  - bit positions of the requesters in request/grant vectors
package regfile_wb_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam int REQ_A = 0;
    localparam int REQ_B = 1;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bundle of the write-back request channels and the register_unit write port.
//
// Signals:
//   a_valid/a_ready/a_rd/a_data - requester A (execute/ALU result) handshake
//   b_valid/b_ready/b_rd/b_data - requester B (memory load result) handshake
//   ru_wr/rd/ru_data_wr         - single write port into register_unit
//   busy                        - high while the post-reset clear runs
// Modports:
//   master - the requester/register side (drives valids, observes the rest)
//   slave  - the arbiter itself
interface regfile_wb_arbiter_if #(
    parameter int amount_of_bits = 32,
    parameter int amount_of_regs = 32,
    parameter int IDX_W          = $clog2(amount_of_regs) + 1
);

    logic                      a_valid;
    logic                      a_ready;
    logic [IDX_W-1:0]          a_rd;
    logic [amount_of_bits-1:0] a_data;

    logic                      b_valid;
    logic                      b_ready;
    logic [IDX_W-1:0]          b_rd;
    logic [amount_of_bits-1:0] b_data;

    logic                      ru_wr;
    logic [IDX_W-1:0]          rd;
    logic [amount_of_bits-1:0] ru_data_wr;
    logic                      busy;

    modport master (
        output a_valid, a_rd, a_data,
        output b_valid, b_rd, b_data,
        input  a_ready, b_ready,
        input  ru_wr, rd, ru_data_wr, busy
    );

    modport slave (
        input  a_valid, a_rd, a_data,
        input  b_valid, b_rd, b_data,
        output a_ready, b_ready,
        output ru_wr, rd, ru_data_wr, busy
    );

endinterface

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter with a one-hot, combinational grant.
//
// Ports:
//   clk, rst_n - clock and asynchronous active-low reset
//   req[1:0]   - requests, indexed by REQ_A / REQ_B
//   en         - arbitration enable; no grant is issued while low
//   grant[1:0] - one-hot grant (all zero when nothing is granted)
module rr_arbiter_2
    import regfile_wb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] grant
);

    // Pointer: 0 favours A, 1 favours B.
    logic fav_b;

    always_comb begin
        grant = '0;
        if (en) begin
            if (req[REQ_A] && req[REQ_B]) begin
                if (fav_b) grant[REQ_B] = 1'b1;
                else       grant[REQ_A] = 1'b1;
            end else begin
                grant = req;
            end
        end
    end

    // Only a contended grant moves the pointer, and it always moves to the
    // loser, so a lone requester can never starve the other one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fav_b <= 1'b0;
        end else if (en && req[REQ_A] && req[REQ_B]) begin
            fav_b <= ~fav_b;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Owner of the register_unit write port: clears every register after reset,
// then arbitrates round-robin between the ALU (A) and load (B) write-backs.
//
// Ports:
//   clk, rst_n - clock and asynchronous active-low reset
//   bus        - regfile_wb_arbiter_if.slave: request handshakes, the
//                registered write port (ru_wr/rd/ru_data_wr) and busy
module regfile_wb_arbiter
    import regfile_wb_pkg::*;
#(
    parameter int amount_of_bits = 32,
    parameter int amount_of_regs = 32,
    parameter int IDX_W          = $clog2(amount_of_regs) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_wb_arbiter_if.slave  bus
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(amount_of_regs - 1);
    localparam logic [IDX_W-1:0] NUM_REGS = IDX_W'(amount_of_regs);

    state_t                    state;
    state_t                    state_next;
    logic [IDX_W-1:0]          clr_idx;
    logic                      run;
    logic [1:0]                req;
    logic [1:0]                grant;
    logic [IDX_W-1:0]          sel_rd;
    logic [amount_of_bits-1:0] sel_data;
    logic                      keep;

    assign run = (state == RUN);

    always_comb begin
        req        = '0;
        req[REQ_A] = bus.a_valid;
        req[REQ_B] = bus.b_valid;
    end

    rr_arbiter_2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .en    (run),
        .grant (grant)
    );

    assign bus.a_ready = grant[REQ_A];
    assign bus.b_ready = grant[REQ_B];

    // busy drops on the same edge that registers the last clear write,
    // because that edge is also the one that enters RUN.
    assign bus.busy    = !run;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= CLEAR;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            CLEAR:   if (clr_idx == LAST_IDX) state_next = RUN;
            RUN:     state_next = RUN;
            default: state_next = CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_idx <= '0;
        end else if (state == CLEAR) begin
            clr_idx <= (clr_idx == LAST_IDX) ? '0 : clr_idx + IDX_W'(1);
        end
    end

    // Register 0 and out-of-range indices complete the handshake but are
    // dropped here, which also keeps the rd MSB clear on every real write.
    always_comb begin
        sel_rd   = grant[REQ_B] ? bus.b_rd   : bus.a_rd;
        sel_data = grant[REQ_B] ? bus.b_data : bus.a_data;
        keep     = (|grant) && (sel_rd != '0) && (sel_rd < NUM_REGS);
    end

    // Single registered output stage; rd/data hold when nothing is written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ru_wr      <= 1'b0;
            bus.rd         <= '0;
            bus.ru_data_wr <= '0;
        end else if (!run) begin
            bus.ru_wr      <= 1'b1;
            bus.rd         <= clr_idx;
            bus.ru_data_wr <= '0;
        end else begin
            bus.ru_wr <= keep;
            if (keep) begin
                bus.rd         <= sel_rd;
                bus.ru_data_wr <= sel_data;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed vectors with literal
// expectations plus a per-cycle comparison against a behavioural model.
module tb_regfile_wb_arbiter;

    localparam int BITS = 32;
    localparam int REGS = 32;
    localparam int IDX  = $clog2(REGS) + 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    int check_count = 0;
    int pass_count  = 0;

    regfile_wb_arbiter_if #(.amount_of_bits(BITS), .amount_of_regs(REGS)) bus ();

    regfile_wb_arbiter #(.amount_of_bits(BITS), .amount_of_regs(REGS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural model: remaining clear writes, who is favoured, and what
    // the write port must show.
    int              m_clear_left = REGS;
    bit              m_fav_b      = 1'b0;
    bit              exp_wr       = 1'b0;
    logic [IDX-1:0]  exp_rd       = '0;
    logic [BITS-1:0] exp_data     = '0;
    logic [1:0]      m_g;
    logic [IDX-1:0]  m_tgt;
    logic [BITS-1:0] m_tdat;
    logic [1:0]      c_g;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        check_count++;
        if (actual === expected) pass_count++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    function automatic logic [1:0] model_grant();
        if (!rst_n || m_clear_left > 0) return 2'b00;
        if (bus.a_valid && bus.b_valid) return m_fav_b ? 2'b10 : 2'b01;
        return {bus.b_valid, bus.a_valid};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_clear_left = REGS;
            m_fav_b      = 1'b0;
            exp_wr       = 1'b0;
            exp_rd       = '0;
            exp_data     = '0;
        end else if (m_clear_left > 0) begin
            exp_wr       = 1'b1;
            exp_rd       = IDX'(REGS - m_clear_left);
            exp_data     = '0;
            m_clear_left = m_clear_left - 1;
        end else begin
            m_g    = model_grant();
            m_tgt  = m_g[1] ? bus.b_rd : bus.a_rd;
            m_tdat = m_g[1] ? bus.b_data : bus.a_data;
            exp_wr = 1'b0;
            if (m_g != 2'b00 && m_tgt != 0 && int'(m_tgt) < REGS) begin
                exp_wr   = 1'b1;
                exp_rd   = m_tgt;
                exp_data = m_tdat;
            end
            if (bus.a_valid && bus.b_valid) m_fav_b = ~m_fav_b;
        end
    end

    always @(negedge clk) begin
        c_g = model_grant();
        checkOutput("cmp a_ready", bus.a_ready, c_g[0]);
        checkOutput("cmp b_ready", bus.b_ready, c_g[1]);
        checkOutput("cmp ru_wr",   bus.ru_wr,   exp_wr);
        checkOutput("cmp busy",    bus.busy,    (!rst_n || m_clear_left > 0));
        if (exp_wr) begin
            checkOutput("cmp rd",         bus.rd,         exp_rd);
            checkOutput("cmp ru_data_wr", bus.ru_data_wr, exp_data);
        end
    end

    task automatic applyStimulus(input logic av, input logic [IDX-1:0] ard,
                                 input logic [BITS-1:0] adat, input logic bv,
                                 input logic [IDX-1:0] brd, input logic [BITS-1:0] bdat);
        bus.a_valid = av;
        bus.a_rd    = ard;
        bus.a_data  = adat;
        bus.b_valid = bv;
        bus.b_rd    = brd;
        bus.b_data  = bdat;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkWrite(input string name, input logic wr,
                              input logic [IDX-1:0] r, input logic [BITS-1:0] d);
        checkOutput({name, " ru_wr"}, bus.ru_wr, wr);
        checkOutput({name, " rd"}, bus.rd, r);
        checkOutput({name, " data"}, bus.ru_data_wr, d);
    endtask

    initial begin
        applyStimulus(1'b1, 6'd3, 32'h3, 1'b0, '0, '0);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkWrite("reset", 1'b0, '0, '0);
        checkOutput("reset busy", bus.busy, 1);
        checkOutput("reset a_ready", bus.a_ready, 0);
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
        #2 rst_n = 1'b1;

        // Full clear sequence after reset release.
        for (int c = 1; c <= REGS; c++) begin
            step();
            checkWrite("clear", 1'b1, IDX'(c - 1), '0);
            checkOutput("clear busy", bus.busy, (c < REGS));
        end

        // Single A write, then idle.
        #1;
        applyStimulus(1'b1, 6'd5, 32'hDEADBEEF, 1'b0, '0, '0);
        #1 checkOutput("single a_ready", bus.a_ready, 1);
        step();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
        checkWrite("single", 1'b1, 6'd5, 32'hDEADBEEF);
        step();
        checkOutput("single idle ru_wr", bus.ru_wr, 0);

        // Contention held for four cycles alternates A,B,A,B.
        applyStimulus(1'b1, 6'd3, 32'h11, 1'b1, 6'd4, 32'h22);
        for (int i = 0; i < 4; i++) begin
            #1;
            checkOutput("rr a_ready", bus.a_ready, (i % 2 == 0));
            checkOutput("rr b_ready", bus.b_ready, (i % 2 == 1));
            step();
            if (i % 2 == 0) checkWrite("rr", 1'b1, 6'd3, 32'h11);
            else            checkWrite("rr", 1'b1, 6'd4, 32'h22);
        end
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);

        // Register 0 and out-of-range indices are accepted but dropped.
        applyStimulus(1'b1, 6'd0, 32'hFFFFFFFF, 1'b0, '0, '0);
        #1 checkOutput("rd0 a_ready", bus.a_ready, 1);
        step();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
        checkOutput("rd0 ru_wr", bus.ru_wr, 0);
        applyStimulus(1'b1, 6'd32, 32'h1234, 1'b0, '0, '0);
        #1 checkOutput("rd32 a_ready", bus.a_ready, 1);
        step();
        applyStimulus(1'b0, '0, '0, 1'b1, 6'd63, 32'h5678);
        checkOutput("rd32 ru_wr", bus.ru_wr, 0);
        #1 checkOutput("rd63 b_ready", bus.b_ready, 1);
        step();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
        checkOutput("rd63 ru_wr", bus.ru_wr, 0);

        // B alone three times leaves the pointer on A.
        for (int j = 0; j < 3; j++) begin
            applyStimulus(1'b0, '0, '0, 1'b1, IDX'(10 + j), 32'hB10 + j);
            #1;
            checkOutput("b-alone b_ready", bus.b_ready, 1);
            checkOutput("b-alone a_ready", bus.a_ready, 0);
            step();
            checkWrite("b-alone", 1'b1, IDX'(10 + j), 32'hB10 + j);
        end
        applyStimulus(1'b1, 6'd13, 32'hA13, 1'b1, 6'd14, 32'hB14);
        #1;
        checkOutput("after-b a_ready", bus.a_ready, 1);
        checkOutput("after-b b_ready", bus.b_ready, 0);
        step();
        checkWrite("after-b A", 1'b1, 6'd13, 32'hA13);
        applyStimulus(1'b0, '0, '0, 1'b1, 6'd14, 32'hB14);
        #1 checkOutput("after-b b_ready2", bus.b_ready, 1);
        step();
        checkWrite("after-b B", 1'b1, 6'd14, 32'hB14);

        // Same destination from both: B favoured now, so A's write lands last.
        applyStimulus(1'b1, 6'd20, 32'hAAAA, 1'b1, 6'd20, 32'hBBBB);
        #1 checkOutput("same-rd b_ready", bus.b_ready, 1);
        step();
        checkWrite("same-rd first", 1'b1, 6'd20, 32'hBBBB);
        applyStimulus(1'b1, 6'd20, 32'hAAAA, 1'b0, '0, '0);
        #1 checkOutput("same-rd a_ready", bus.a_ready, 1);
        step();
        checkWrite("same-rd last", 1'b1, 6'd20, 32'hAAAA);
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);

        // Asynchronous reset while a write is on the port, then mid-clear.
        #1 rst_n = 1'b0;
        #1 checkWrite("async rst", 1'b0, '0, '0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            step();
            checkWrite("clear-a", 1'b1, IDX'(c - 1), '0);
        end
        #2 rst_n = 1'b0;
        #1;
        checkWrite("midclear rst", 1'b0, '0, '0);
        checkOutput("midclear busy", bus.busy, 1);
        applyStimulus(1'b1, 6'd7, 32'h77, 1'b1, 6'd8, 32'h88);
        @(posedge clk);
        #2 rst_n = 1'b1;
        for (int c = 1; c <= REGS; c++) begin
            step();
            checkWrite("clear-b", 1'b1, IDX'(c - 1), '0);
            #1;
            checkOutput("clear-b a_ready", bus.a_ready, (c == REGS));
            checkOutput("clear-b b_ready", bus.b_ready, 0);
        end
        step();
        checkWrite("post-clear A", 1'b1, 6'd7, 32'h77);
        applyStimulus(1'b0, '0, '0, 1'b1, 6'd8, 32'h88);
        #1 checkOutput("post-clear b_ready", bus.b_ready, 1);
        step();
        checkWrite("post-clear B", 1'b1, 6'd8, 32'h88);
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
        step();
        checkOutput("final idle ru_wr", bus.ru_wr, 0);
        repeat (2) @(posedge clk);
        #2;

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Owns the single write port of register_unit. After reset it runs a clear sequence that zeroes every register, one per cycle. It then arbitrates between two write-back requesters over valid/ready handshakes:
- Requester A: execute/ALU result.
- Requester B: memory load result.

Arbitration is round-robin. The winning write is driven onto ru_wr/rd/ru_data_wr through one registered stage.

Parameters:
amount_of_bits, 32, data width; matches register_unit.
amount_of_regs, 32, number of registers; matches register_unit.
IDX_W, $clog2(amount_of_regs)+1, width of rd and all register indices; matches the register_unit rd/rs port width.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst_n  in  1  asynchronous, active-low reset.
a_valid  in  1  requester A has a write pending.
a_ready  out  1  A's write is accepted this cycle.
a_rd  in  IDX_W  A's destination index.
a_data  in  amount_of_bits  A's write data.
b_valid  in  1  requester B has a write pending.
b_ready  out  1  B's write is accepted this cycle.
b_rd  in  IDX_W  B's destination index.
b_data  in  amount_of_bits  B's write data.
ru_wr  out  1  write enable to register_unit.
rd  out  IDX_W  write index to register_unit.
ru_data_wr  out  amount_of_bits  write data to register_unit.
busy  out  1  high while the clear sequence runs.

Behaviour:
- Reset (asynchronous, any time, including mid-clear or mid-write):
  - state=CLEAR, clear index=0, rr pointer favours A.
  - ru_wr=0, rd=0, ru_data_wr=0, a_ready=0, b_ready=0, busy=1.
- CLEAR state:
  - Each cycle registers ru_wr=1, rd=idx, ru_data_wr=0, then increments idx.
  - After idx=amount_of_regs-1 is issued, the next state is RUN and idx returns to 0.
  - Clear output writes appear on cycles 1..amount_of_regs after reset release; busy falls together with the last clear write (cycle amount_of_regs).
  - a_ready=b_ready=0 throughout CLEAR; valid inputs are ignored and held by the requesters.
- RUN state:
  - Readies are combinational from valids and the rr pointer. At most one ready is high per cycle.
  - Only one requester valid: that requester gets ready.
  - Both valid: the requester indicated by the rr pointer wins. After each contended grant the pointer flips to the loser.
  - Uncontended grants leave the pointer unchanged.
  - Handshake = valid & ready in cycle k. The output stage then holds ru_wr=1, rd=granted rd, ru_data_wr=granted data in cycle k+1. Latency is exactly 1 cycle.
  - No accepted handshake in cycle k: ru_wr=0 in k+1. rd and ru_data_wr hold their previous values.
  - rd==0 writes are accepted (ready high, handshake completes) but discarded: ru_wr stays 0. Register 0 stays zero.
  - Index >= amount_of_regs: accepted and discarded, same as rd==0.
  - A requester must hold valid, rd and data stable until ready. Same-rd requests from A and B are serialized in grant order; the later-granted write wins.
  - Back-to-back handshakes sustain one write per cycle.
- Width rules:
  - rd output MSB is zero whenever ru_wr=1.
  - Clear index counter is IDX_W bits; it never wraps during CLEAR because it stops at amount_of_regs-1.

Decomposition:
- Package regfile_wb_pkg holds:
  - state enum: CLEAR, RUN.
  - requester id constants: REQ_A=0, REQ_B=1.
- Sub-module rr_arbiter_2:
  - Inputs: two requests, enable.
  - Outputs: one-hot grant; owns the rr pointer flop, updated only on contended grant.
- The top level holds the FSM, clear counter and output register stage.

Test Plan:
- Release rst_n with amount_of_regs=32 -> ru_wr=1 for 32 consecutive cycles with rd=0..31 and ru_data_wr=0; busy falls with the rd=31 write; readies stay 0 throughout.
- RUN, a_valid=1, a_rd=5, a_data=0xDEADBEEF for one cycle -> a_ready=1 that cycle; next cycle ru_wr=1, rd=5, ru_data_wr=0xDEADBEEF; the cycle after, ru_wr=0.
- RUN, both valid held 4 cycles (A: rd=3 data=0x11, B: rd=4 data=0x22) -> grants A,B,A,B; outputs alternate rd=3/4 with one write per cycle.
- RUN, a_valid=1, a_rd=0, a_data=0xFFFFFFFF -> a_ready=1; next cycle ru_wr=0.
- Assert rst_n=0 at cycle 10 of clear, release -> outputs zero immediately on assertion; the clear sequence restarts from rd=0 and runs a full 32 writes.
- RUN, B alone valid for 3 cycles, then A and B together -> B's 3 uncontended grants leave the pointer at A, so A wins the contended cycle.
